// File: rtl/mcb_port_arbiter_if.sv
// Bundle of client, MCB command-port and status signals shared by the
// write client, the read client and mcb_port_arbiter.
// slave  : arbiter side (drives acks, MCB command fields and status)
// master : client/MCB side (drives requests, monitors and MCB status)
interface mcb_port_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              calib_done;
    logic              wr_req;
    logic [5:0]        wr_bl;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ack;
    logic              rd_req;
    logic [5:0]        rd_bl;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              mcb_cmd_en;
    logic [2:0]        mcb_cmd_instr;
    logic [5:0]        mcb_cmd_bl;
    logic [ADDR_W-1:0] mcb_cmd_addr;
    logic              mcb_cmd_full;
    logic              mcb_wr_en_mon;
    logic              mcb_rd_en_mon;
    logic              mcb_rd_empty;
    logic              busy;
    logic              err;

    modport slave (
        input  calib_done, wr_req, wr_bl, wr_addr, rd_req, rd_bl, rd_addr,
               mcb_cmd_full, mcb_wr_en_mon, mcb_rd_en_mon, mcb_rd_empty,
        output wr_ack, rd_ack, mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl,
               mcb_cmd_addr, busy, err
    );

    modport master (
        output calib_done, wr_req, wr_bl, wr_addr, rd_req, rd_bl, rd_addr,
               mcb_cmd_full, mcb_wr_en_mon, mcb_rd_en_mon, mcb_rd_empty,
        input  wr_ack, rd_ack, mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl,
               mcb_cmd_addr, busy, err
    );
endinterface

// File: rtl/mcb_port_arbiter.sv
// mcb_port_arbiter: shares one MCB user port between a write client and a
// read client. A write command is issued only once its whole burst sits
// uncommitted in the MCB write FIFO; a read command only once the read FIFO
// has room reserved for the whole burst. Round-robin on ties.
// Optional feature macro: MCB_ARB_AUTO_PRECHARGE_EN selects the
// auto-precharge command encodings (write 3'b010, read 3'b011).
module mcb_port_arbiter #(
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 30,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mcb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES - 1);

`ifdef MCB_ARB_AUTO_PRECHARGE_EN
    localparam logic [2:0] WR_INSTR = 3'b010;
    localparam logic [2:0] RD_INSTR = 3'b011;
`else
    localparam logic [2:0] WR_INSTR = 3'b000;
    localparam logic [2:0] RD_INSTR = 3'b001;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_gap_cnt;
    logic [3:0]        w_gap_cnt_next;
    logic              r_last_rd;      // 1: last grant went to the read client
    logic              r_issue_wr;     // command in flight is a write
    logic [2:0]        r_cmd_instr;
    logic [5:0]        r_cmd_bl;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [CNT_W-1:0]  r_wr_pend;
    logic [CNT_W-1:0]  r_rd_resv;
    logic              r_err;

    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_cmd_en;
    logic [CNT_W:0]    w_wr_need;
    logic [CNT_W:0]    w_rd_need;
    logic [CNT_W:0]    w_rd_total;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_can_grant;
    logic              w_rd_pop;
    logic [CNT_W+1:0]  w_pend_sum;
    logic [CNT_W+1:0]  w_resv_sum;
    logic              w_wr_ovf;
    logic              w_rd_unf;

    // Eligibility sums are one bit wider than the counters so nothing wraps.
    assign w_wr_need   = (CNT_W+1)'(bus.wr_bl) + (CNT_W+1)'(1);
    assign w_rd_need   = (CNT_W+1)'(bus.rd_bl) + (CNT_W+1)'(1);
    assign w_rd_total  = (CNT_W+1)'(r_rd_resv) + w_rd_need;
    assign w_wr_ok     = bus.wr_req && ({1'b0, r_wr_pend} >= w_wr_need);
    assign w_rd_ok     = bus.rd_req && (w_rd_total <= (CNT_W+1)'(FIFO_DEPTH));
    assign w_can_grant = bus.calib_done && !bus.mcb_cmd_full;
    assign w_rd_pop    = bus.mcb_rd_en_mon && !bus.mcb_rd_empty;

    // State register and gap counter.
    // NOTE: every flop in this block uses <= so all of them sample the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    // Next-state, grant selection and command-enable decode.
    // NOTE: each signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        w_grant_wr     = 1'b0;
        w_grant_rd     = 1'b0;
        w_cmd_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_can_grant && (w_wr_ok || w_rd_ok)) begin
                    if (w_wr_ok && w_rd_ok) begin
                        w_grant_wr = r_last_rd;
                        w_grant_rd = !r_last_rd;
                    end else begin
                        w_grant_wr = w_wr_ok;
                        w_grant_rd = w_rd_ok;
                    end
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cmd_en       = 1'b1;
                w_gap_cnt_next = GAP_LOAD;
                w_next_state   = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the pending-write and reserved-read word counters.
    always_comb begin
        w_pend_sum = (CNT_W+2)'(r_wr_pend) + (CNT_W+2)'(bus.mcb_wr_en_mon);
        if (w_grant_wr) begin
            w_pend_sum = w_pend_sum - (CNT_W+2)'(w_wr_need);
        end
        w_wr_ovf = (w_pend_sum > (CNT_W+2)'(CNT_MAX));

        w_resv_sum = (CNT_W+2)'(r_rd_resv);
        if (w_grant_rd) begin
            w_resv_sum = w_resv_sum + (CNT_W+2)'(w_rd_need);
        end
        w_rd_unf = 1'b0;
        if (w_rd_pop) begin
            if (w_resv_sum == '0) begin
                w_rd_unf = 1'b1;
            end else begin
                w_resv_sum = w_resv_sum - (CNT_W+2)'(1);
            end
        end
    end

    // Counters, sticky error flag, grant history and latched command fields.
    // NOTE: the command fields are reset too, so the MCB sees defined values
    // even before the first grant; there is no memory array to leave unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pend   <= '0;
            r_rd_resv   <= '0;
            r_err       <= 1'b0;
            r_last_rd   <= 1'b1;
            r_issue_wr  <= 1'b0;
            r_cmd_instr <= '0;
            r_cmd_bl    <= '0;
            r_cmd_addr  <= '0;
        end else begin
            r_wr_pend <= w_wr_ovf ? CNT_MAX : CNT_W'(w_pend_sum);
            r_rd_resv <= CNT_W'(w_resv_sum);
            r_err     <= r_err | w_wr_ovf | w_rd_unf;
            if (w_grant_wr) begin
                r_last_rd   <= 1'b0;
                r_issue_wr  <= 1'b1;
                r_cmd_instr <= WR_INSTR;
                r_cmd_bl    <= bus.wr_bl;
                r_cmd_addr  <= bus.wr_addr;
            end else if (w_grant_rd) begin
                r_last_rd   <= 1'b1;
                r_issue_wr  <= 1'b0;
                r_cmd_instr <= RD_INSTR;
                r_cmd_bl    <= bus.rd_bl;
                r_cmd_addr  <= bus.rd_addr;
            end
        end
    end

    // cmd_en and the acks decode straight from state so an async reset drops
    // them at once.
    assign bus.mcb_cmd_en    = w_cmd_en;
    assign bus.wr_ack        = w_cmd_en && r_issue_wr;
    assign bus.rd_ack        = w_cmd_en && !r_issue_wr;
    assign bus.mcb_cmd_instr = r_cmd_instr;
    assign bus.mcb_cmd_bl    = r_cmd_bl;
    assign bus.mcb_cmd_addr  = r_cmd_addr;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.err           = r_err;

endmodule
